// File: rtl/du_inst_loader_pkg.sv
// Shared types and constants for the debug-unit instruction loader.
package du_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } du_state_t;

  localparam int unsigned DU_NB_DATA   = 8;
  localparam logic [31:0] DU_HALT_INST = 32'hFFFF_FFFF;
  localparam int unsigned DU_TIMEOUT   = 50_000_000;

endpackage

// File: rtl/du_inst_loader_if.sv
// UART-byte input side and instruction-memory write side of the loader.
interface du_inst_loader_if
  import du_pkg::*;
#(
  parameter int unsigned NB_DATA = DU_NB_DATA,
  parameter int unsigned NB_INST = 32,
  parameter int unsigned NB_ADDR = 32
) ();

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_INST-1:0] o_inst_data;
  logic [NB_ADDR-1:0] o_inst_addr;
  logic               o_inst_we;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_inst_data, o_inst_addr, o_inst_we
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_inst_data, o_inst_addr, o_inst_we
  );

endinterface

// File: rtl/du_inst_loader.sv
// Assembles UART bytes MSB-first into instruction words and writes them to
// consecutive addresses until HALT, capacity exhaustion or a mid-word timeout.
module du_inst_loader
  import du_pkg::*;
#(
  parameter int unsigned       NB_DATA   = DU_NB_DATA,
  parameter int unsigned       NB_INST   = 32,
  parameter int unsigned       NB_ADDR   = 32,
  parameter int unsigned       MAX_INST  = 256,
  parameter int unsigned       NB_CNT    = 9,
  parameter int unsigned       TIMEOUT   = DU_TIMEOUT,
  parameter logic [NB_INST-1:0] HALT_INST = NB_INST'(DU_HALT_INST)
) (
  input  logic              i_du_clk,
  input  logic              i_du_reset,
  input  logic              i_start,
  du_inst_loader_if.master  bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [NB_CNT-1:0] o_word_count
);

  localparam int unsigned       NB_ASM  = NB_INST - NB_DATA;
  localparam int unsigned       NB_TO   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NB_TO-1:0]  TO_LAST = NB_TO'(TIMEOUT - 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(MAX_INST);

  du_state_t          state_q, state_d;
  logic [1:0]         idx_q;
  logic [NB_ASM-1:0]  asm_q;
  logic [NB_TO-1:0]   to_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_ADDR-1:0] wr_addr_q;
  logic [NB_INST-1:0] data_q;
  logic [NB_CNT-1:0]  cnt_q;

  logic restart, take_byte, last_byte, timed_out;

  always_comb begin
    restart   = i_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    // The WRITE cycle also accepts a byte so back-to-back words lose nothing.
    take_byte = bus.i_rx_valid && (state_q inside {ST_RECV, ST_WRITE});
    last_byte = take_byte && (state_q == ST_RECV) && (idx_q == 2'd3);
    timed_out = (state_q == ST_RECV) && !bus.i_rx_valid && (idx_q != 2'd0)
                && (to_q == TO_LAST);

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (restart) state_d = ST_RECV;
      ST_RECV: begin
        if (last_byte)      state_d = ST_WRITE;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_WRITE: begin
        if (data_q == HALT_INST)               state_d = ST_DONE;
        else if (cnt_q + 1'b1 == CNT_MAX)      state_d = ST_ERROR;
        else                                   state_d = ST_RECV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_du_clk) begin
    if (i_du_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_du_clk) begin
    if (i_du_reset) begin
      idx_q     <= '0;
      asm_q     <= '0;
      to_q      <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (restart) begin
        idx_q  <= '0;
        to_q   <= '0;
        addr_q <= '0;
        cnt_q  <= '0;
      end
      if (take_byte) begin
        asm_q <= {asm_q[NB_ASM-NB_DATA-1:0], bus.i_rx_data};
        idx_q <= idx_q + 2'd1;
        to_q  <= '0;
      end else if (state_q == ST_RECV && idx_q != 2'd0) begin
        to_q  <= to_q + 1'b1;
      end
      // Latch the write payload separately so the outputs hold while the
      // next word is being assembled.
      if (last_byte) begin
        data_q    <= {asm_q, bus.i_rx_data};
        wr_addr_q <= addr_q;
      end
      if (state_q == ST_WRITE) begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= addr_q + NB_ADDR'(4);
      end
    end
  end

  assign bus.o_inst_we   = (state_q == ST_WRITE);
  assign bus.o_inst_data = data_q;
  assign bus.o_inst_addr = wr_addr_q;
  assign o_busy          = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_done          = (state_q == ST_DONE);
  assign o_error         = (state_q == ST_ERROR);
  assign o_word_count    = cnt_q;

endmodule

// File: tb/tb_du_inst_loader.sv
// Directed and randomized checks of du_inst_loader against a word-level model.
module tb_du_inst_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [8:0] wcnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];

  du_inst_loader_if bus ();

  du_inst_loader #(
    .MAX_INST (4),
    .TIMEOUT  (100)
  ) dut (
    .i_du_clk     (clk),
    .i_du_reset   (rst),
    .i_start      (start),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (err),
    .o_word_count (wcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.o_inst_we === 1'b1) wr_q.push_back({bus.o_inst_addr, bus.o_inst_data});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    step();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if (i > 0 && gap > 0) step($urandom_range(0, gap));
    end
  endtask

  // Word-level view of one load: consecutive word addresses, stop at HALT or capacity 4.
  task automatic model_load(input logic [31:0] w[$], output bit e_done,
                            output bit e_err, output int e_cnt);
    e_done = 1'b0;
    e_err  = 1'b0;
    e_cnt  = 0;
    foreach (w[k]) begin
      if (e_done || e_err) break;
      exp_q.push_back({32'(4 * k), w[k]});
      e_cnt++;
      if (w[k] == 32'hFFFF_FFFF) e_done = 1'b1;
      else if (e_cnt == 4)       e_err  = 1'b1;
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k])
      if (k < wr_q.size()) chk(tag, wr_q[k], exp_q[k]);
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[$];
    bit e_done, e_err;
    int e_cnt;

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    step(3);
    chk("rst_flags", 64'({busy, done, err, bus.o_inst_we, wcnt}), 64'(0));
    chk("rst_data", 64'(bus.o_inst_data), 64'(0));
    chk("rst_addr", 64'(bus.o_inst_addr), 64'(0));
    rst = 1'b0;

    // Bytes while idle are ignored.
    repeat (8) send_byte(8'($urandom));
    chk("idle_busy", 64'(busy), 64'(0));
    check_writes("idle_wr");

    // Basic two-word program ending in HALT, with latency checks.
    pulse_start();
    chk("t1_busy", 64'(busy), 64'(1));
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
    chk("t1_we_early", 64'(bus.o_inst_we), 64'(0));
    send_byte(8'h05);
    chk("t1_we", 64'(bus.o_inst_we), 64'(1));
    chk("t1_data0", 64'(bus.o_inst_data), 64'h2008_0005);
    chk("t1_addr0", 64'(bus.o_inst_addr), 64'(0));
    chk("t1_cnt_in_write", 64'(wcnt), 64'(0));
    send_byte(8'hFF);
    chk("t1_we_width", 64'(bus.o_inst_we), 64'(0));
    chk("t1_cnt_after", 64'(wcnt), 64'(1));
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    chk("t1_data1", 64'(bus.o_inst_data), 64'hFFFF_FFFF);
    chk("t1_addr1", 64'(bus.o_inst_addr), 64'(4));
    chk("t1_done_early", 64'(done), 64'(0));
    step();
    chk("t1_end", 64'({done, err, busy}), 64'(3'b100));
    chk("t1_cnt", 64'(wcnt), 64'(2));
    exp_q.push_back({32'd0, 32'h2008_0005});
    exp_q.push_back({32'd4, 32'hFFFF_FFFF});
    check_writes("t1_wr");

    // Back-to-back words: byte in the WRITE cycle becomes the next MSB.
    pulse_start();
    chk("t2_restart", 64'({done, busy, wcnt}), 64'({2'b01, 9'd0}));
    send_word(32'hA1B2_C3D4, 0);
    send_word(32'hE5F6_0718, 0);
    send_word(32'hFFFF_FFFF, 0);
    step();
    chk("t2_done", 64'({done, wcnt}), 64'({1'b1, 9'd3}));
    words = '{32'hA1B2_C3D4, 32'hE5F6_0718, 32'hFFFF_FFFF};
    model_load(words, e_done, e_err, e_cnt);
    check_writes("t2_wr");

    // Capacity exhausted without HALT.
    pulse_start();
    words = '{32'h0000_0011, 32'h2222_0000, 32'h3333_3333, 32'h4000_0004};
    foreach (words[k]) send_word(words[k], 2);
    chk("t3_err_early", 64'(err), 64'(0));
    step();
    chk("t3_flags", 64'({err, done, busy}), 64'(3'b100));
    chk("t3_cnt", 64'(wcnt), 64'(4));
    model_load(words, e_done, e_err, e_cnt);
    send_word(32'h1234_5678, 0);
    chk("t3_err_sticky", 64'(err), 64'(1));
    check_writes("t3_wr");

    // Mid-word timeout.
    pulse_start();
    chk("t4_err_cleared", 64'(err), 64'(0));
    send_byte(8'h12); send_byte(8'h34);
    step(99);
    chk("t4_no_err_yet", 64'({err, busy}), 64'(2'b01));
    step();
    chk("t4_timeout", 64'({err, busy}), 64'(2'b10));
    check_writes("t4_no_wr");

    // Long silence between whole words is not a timeout.
    pulse_start();
    send_word(32'h0BAD_F00D, 1);
    step(1000);
    chk("t4_idle_ok", 64'({err, busy}), 64'(2'b01));
    send_word(32'hFFFF_FFFF, 1);
    step();
    chk("t4_done", 64'({done, err}), 64'(2'b10));
    words = '{32'h0BAD_F00D, 32'hFFFF_FFFF};
    model_load(words, e_done, e_err, e_cnt);
    check_writes("t4_wr");

    // Start mid-RECV is ignored.
    pulse_start();
    send_word(32'h1122_3344, 0);
    send_byte(8'h55); send_byte(8'h66);
    pulse_start();
    chk("t5_ignored", 64'({busy, wcnt}), 64'({1'b1, 9'd1}));
    send_byte(8'h77); send_byte(8'h88);
    send_word(32'hFFFF_FFFF, 0);
    step();
    chk("t5_done", 64'({done, wcnt}), 64'({1'b1, 9'd3}));
    words = '{32'h1122_3344, 32'h5566_7788, 32'hFFFF_FFFF};
    model_load(words, e_done, e_err, e_cnt);
    check_writes("t5_wr");

    // Restart from DONE, then reset arriving with the 4th byte.
    pulse_start();
    chk("t5_restart_cnt", 64'({done, wcnt}), 64'(0));
    send_word(32'hCAFE_0001, 0);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    rst = 1'b1;
    send_byte(8'hEF);
    chk("t5_rst_flags", 64'({busy, done, err, bus.o_inst_we, wcnt}), 64'(0));
    chk("t5_rst_data", 64'(bus.o_inst_data), 64'(0));
    chk("t5_rst_addr", 64'(bus.o_inst_addr), 64'(0));
    rst = 1'b0;
    step();
    exp_q.push_back({32'd0, 32'hCAFE_0001});
    check_writes("t5_wr_rst");

    // Randomized loads with random HALT placement and byte gaps.
    for (int r = 0; r < 20; r++) begin
      words.delete();
      for (int k = 0; k < 4; k++)
        words.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      pulse_start();
      foreach (words[k]) send_word(words[k], 3);
      step(2);
      model_load(words, e_done, e_err, e_cnt);
      chk("rnd_done", 64'(done), 64'(e_done));
      chk("rnd_err", 64'(err), 64'(e_err));
      chk("rnd_cnt", 64'(wcnt), 64'(e_cnt));
      check_writes("rnd_wr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/du_inst_loader.md
Name: du_inst_loader

Overview:
- Debug-unit stage that turns UART RX bytes into 32-bit instruction-memory writes for the pipeline.
- Sits between the UART RX FIFO pop path and the pipeline inputs i_du_data, i_du_inst_addr_wr and i_du_write_en.
- It is armed by the debug command FSM and assembles bytes MSB-first into words.
- Words are written to consecutive addresses until the HALT word has been stored, capacity runs out, or a mid-word timeout occurs.

Parameters:
- NB_DATA, 8, UART byte width
- NB_INST, 32, instruction word width
- NB_ADDR, 32, instruction-memory byte address width
- MAX_INST, 256, instruction-memory capacity in words
- NB_CNT, 9, word-counter width (must hold MAX_INST)
- TIMEOUT, 50_000_000, idle cycles allowed between bytes of one word (1 s at 50 MHz)
- HALT_INST, 32'hFFFF_FFFF, end-of-program marker

Ports:
- i_du_clk  in  1  system clock (50 MHz domain)
- i_du_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse from command FSM: begin a load
- i_rx_data  in  NB_DATA  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
- o_inst_data  out  NB_INST  word to write
- o_inst_addr  out  NB_ADDR  byte address of the word
- o_inst_we  out  1  write strobe to instruction memory
- o_busy  out  1  high in RECV and WRITE
- o_done  out  1  load finished with HALT stored; sticky
- o_error  out  1  overflow or timeout; sticky
- o_word_count  out  NB_CNT  words written in the current load, HALT included

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, including o_inst_data and o_inst_addr.
  - Internal byte index, assembly register and timeout counter are 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_start moves to RECV.
  - On entry to RECV: address = 0, o_word_count = 0, byte index = 0, timeout counter = 0.
  - i_rx_valid is ignored.
- RECV:
  - On each i_rx_valid, the assembly register becomes {asm[23:0], i_rx_data}, byte index increments and the timeout counter clears.
  - When the 4th byte is accepted (byte index 3 -> 0), the next state is WRITE.
- WRITE (exactly 1 cycle):
  - o_inst_we = 1, o_inst_data = assembled word, o_inst_addr = current address.
  - o_word_count increments in this cycle and is visible the following cycle.
  - Next state:
    - word == HALT_INST -> DONE;
    - else word count reaches MAX_INST -> ERROR (capacity exhausted with no HALT);
    - else address += 4 -> RECV.
  - An i_rx_valid arriving in the WRITE cycle is accepted as byte 0 of the next word. No bytes are lost.
- Latency:
  - 4th byte strobed at cycle N -> o_inst_we high at N+1.
  - o_done or o_error high from N+2.
- Timeout:
  - The counter runs only in RECV with byte index != 0. It waits indefinitely between words.
  - Reaching TIMEOUT-1 without a byte -> ERROR. The partial word is never written.
- DONE / ERROR:
  - o_done or o_error is held high and o_busy is low.
  - i_start clears the flag and starts a new load exactly as from IDLE.
  - No other exit except reset.
- i_start while in RECV or WRITE is ignored.
- o_inst_we is never asserted outside WRITE. o_inst_data and o_inst_addr hold their last values otherwise.
- o_inst_addr arithmetic is modulo 2^NB_ADDR. In practice it is bounded by 4*(MAX_INST-1).
- Reset mid-operation: immediate return to IDLE with reset values. No write occurs in the reset cycle.
- Simultaneous i_start and i_rx_valid in IDLE/DONE/ERROR: the load starts and the byte is discarded.

Decomposition:
- Shared package du_pkg holds:
  - the state enum (IDLE, RECV, WRITE, DONE, ERROR);
  - HALT_INST;
  - the UART byte width;
  - the default TIMEOUT at 50 MHz.
- No sub-module. The byte assembler, timeout counter and FSM are a single block.

Test Plan:
1. Reset, then i_start, then bytes 20 08 00 05, FF FF FF FF -> we at addr 0 data 0x20080005, we at addr 4 data 0xFFFFFFFF; o_done=1, o_word_count=2, o_error=0.
2. 4th byte at cycle N -> o_inst_we only at N+1, width 1 cycle; a byte strobed at N+1 appears as MSB of the next word.
3. MAX_INST=4 override, 4 non-HALT words -> 4 writes at addrs 0,4,8,12, then o_error=1, o_done=0, o_word_count=4.
4. TIMEOUT=100 override, send 2 bytes then silence -> o_error after 100 idle cycles, no write; 1000 idle cycles between whole words -> no error.
5. i_start mid-RECV is ignored; i_start in DONE restarts with addr 0 and count 0; i_du_reset asserted after byte 3 -> no write, all outputs 0 the next cycle.
6. Bytes while IDLE -> no writes, o_busy stays 0.
